reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised multi-source reset controller that replaces the fixed three-output reset controller in the reset tree. It glitch-filters NUM_SRC asynchronous reset requests plus a software request, stretches the combined request, and releases NUM_OUT reset outputs one after another with a programmable gap. A sticky cause register records what triggered each reset.

## Interface
- NUM_SRC, 2: number of external async reset request inputs (≥1)
- NUM_OUT, 3: number of sequenced reset outputs (≥1)
- SYNC_STAGES, 2: synchroniser depth per source (≥2)
- FILT_CYCLES, 4: consecutive synced-high samples needed to qualify a request (≥1)
- STRETCH_CYCLES, 8: request-free cycles before the first release (≥1)
- GAP_CYCLES, 5: cycles between successive output releases (≥1)

- clk  in  1  single block clock
- i_rst  in  1  asynchronous, active-high block reset (POR)
- i_src_rst  in  NUM_SRC  raw async reset requests, active-high
- i_src_en  in  NUM_SRC  per-source enable; a masked source never triggers a reset
- i_sw_rst  in  1  synchronous single-cycle software reset request
- i_cause_clr  in  1  synchronous clear of o_cause
- o_rst  out  NUM_OUT  sequenced resets, active-high, bit 0 released first
- o_busy  out  1  high whenever any o_rst bit is high
- o_cause  out  NUM_SRC+2  sticky cause: bit 0 POR, bits 1..NUM_SRC sources, bit NUM_SRC+1 software

## Operation
- Per source: SYNC_STAGES flop synchroniser (reset to 0), then a saturating counter of consecutive synced-1 samples. Filtered output is high while the count is at least FILT_CYCLES. Any synced 0 clears the count and the filtered output on that edge.
- Internal req = OR over k of (filt[k] & i_src_en[k]), OR'd with i_sw_rst.
- FSM states are ASSERT, STRETCH, RELEASE, RUN.
  - ASSERT: o_rst all 1. Moves to STRETCH on the first edge that samples req=0. That edge is "edge 1" and loads the stretch counter.
  - STRETCH: o_rst all 1. req=1 returns to ASSERT. After STRETCH_CYCLES req-free edges, moves to RELEASE and clears o_rst[0] on the same edge.
  - RELEASE: clears o_rst[k] GAP_CYCLES edges after o_rst[k-1]. Moves to RUN on the edge that clears o_rst[NUM_OUT-1]. With NUM_OUT=1, goes directly from STRETCH to RUN.
  - RUN: o_rst all 0.
- req=1 in STRETCH, RELEASE or RUN sets all o_rst bits on the next edge, enters ASSERT, and restarts the full stretch.
- o_cause: a bit is set on the edge at which its request contributes to req, in any state. The software bit is set by i_sw_rst. Setting wins over a coincident i_cause_clr.
- i_rst forces the following immediately, with no clock required:
  - o_rst all 1, o_busy 1, state ASSERT
  - o_cause = 1 (POR bit set only)
  - all counters and synchronisers cleared
- i_cause_clr clears the POR bit like any other bit.

## Timing
- Reset values: o_rst all 1, o_busy 1, o_cause = 1.
- Source assert latency: a raw rise before edge 1 qualifies after edge SYNC_STAGES+FILT_CYCLES. o_rst goes high after edge SYNC_STAGES+FILT_CYCLES+1, which is 7 edges at the defaults. A synced pulse shorter than FILT_CYCLES samples is ignored.
- Software assert latency: o_rst goes high on the edge after i_sw_rst is sampled.
- Release: o_rst[k] falls on edge STRETCH_CYCLES + k*GAP_CYCLES.
  - Defaults: edges 8, 13, 18.
  - o_busy falls with o_rst[NUM_OUT-1].
- All outputs are registered; there are no combinational input-to-output paths.
- Counter widths are $clog2(max count + 1).

## Structure
- reset_seq_pkg holds:
  - the state enum
  - the cause bit index constants (CAUSE_POR=0, CAUSE_SRC_BASE=1, CAUSE_SW=NUM_SRC+1 as a function)
  - a count-width helper function
- Sub-module reset_glitch_filter contains the synchroniser and the FILT_CYCLES counter. It is instantiated NUM_SRC times via generate.

## Test plan
- POR: hold i_rst for 3 cycles, then release with no requests.
  - o_rst = 111 → 110 at edge 8 → 100 at edge 13 → 000 at edge 18.
  - o_busy falls at edge 18; o_cause = 4'b0001.
- Glitch: in RUN, raise i_src_rst[0] for 2 cycles.
  - o_rst stays 000 and o_cause is unchanged.
  - Repeat with a 4-cycle pulse: o_rst = 111 seven edges after the rise, and o_cause[1] is set.
- Retrigger: pulse i_sw_rst one cycle after o_rst[0] falls.
  - o_rst = 111 on the next edge and o_cause[3] is set.
  - The release restarts with o_rst[0] falling 8 edges after the request clears.
- Mask: set i_src_en[1]=0 and hold i_src_rst[1] for 20 cycles.
  - No change to o_rst or o_cause.
  - Enable mid-pulse: the reset asserts on the next edge.
- Cause: assert i_cause_clr on the same edge that source 0 sets its bit → o_cause[1] = 1. A lone i_cause_clr → o_cause = 0.
- Async: assert i_rst mid-RUN with clk stopped → o_rst = 111 immediately and o_cause = 0001.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, cause bit
// positions and counter sizing.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_STRETCH,
    ST_RELEASE,
    ST_RUN
  } state_e;

  localparam int unsigned CAUSE_POR      = 0;
  localparam int unsigned CAUSE_SRC_BASE = 1;

  function automatic int unsigned cause_sw(input int unsigned num_src);
    return num_src + 1;
  endfunction

  // Bits needed to hold 0..max_count inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/reset_glitch_filter.sv
// Synchronises one raw reset request and qualifies it only after FILT_CYCLES
// consecutive synced-high samples.
module reset_glitch_filter
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt_c
);

  localparam int unsigned CW = cnt_width(FILT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;

  // Saturating run-length counter; any synced low restarts qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (!sync_q[SYNC_STAGES-1]) begin
        cnt_q <= '0;
      end else if (cnt_q != CW'(FILT_CYCLES)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign filt_c = (cnt_q == CW'(FILT_CYCLES));

endmodule

// File: rtl/reset_sequencer.sv
// Multi-source reset controller: filters requests, stretches the combined
// request, then releases the outputs in order with a fixed gap.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned NUM_OUT        = 3,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILT_CYCLES    = 4,
  parameter int unsigned STRETCH_CYCLES = 8,
  parameter int unsigned GAP_CYCLES     = 5
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NUM_SRC-1:0] i_src_rst,
  input  logic [NUM_SRC-1:0] i_src_en,
  input  logic               i_sw_rst,
  input  logic               i_cause_clr,
  output logic [NUM_OUT-1:0] o_rst,
  output logic               o_busy,
  output logic [NUM_SRC+1:0] o_cause
);

  localparam int unsigned SCW     = cnt_width(STRETCH_CYCLES);
  localparam int unsigned GCW     = cnt_width(GAP_CYCLES);
  localparam int unsigned OCW     = cnt_width(NUM_OUT);
  localparam int unsigned CAUSE_W = NUM_SRC + 2;
  localparam int unsigned SW_BIT  = cause_sw(NUM_SRC);

  logic [NUM_SRC-1:0] filt_c;
  logic [NUM_SRC-1:0] src_req_c;
  logic               req_c;
  logic               release_now_c;
  logic [CAUSE_W-1:0] cause_set_c;

  state_e         state_q;
  logic [SCW-1:0] stretch_q;
  logic [GCW-1:0] gap_q;
  logic [OCW-1:0] idx_q;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_filt
    reset_glitch_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_filt (
      .clk    (clk),
      .rst    (i_rst),
      .raw    (i_src_rst[k]),
      .filt_c (filt_c[k])
    );
  end

  assign src_req_c = filt_c & i_src_en;
  assign req_c     = (|src_req_c) | i_sw_rst;

  // The edge that completes the stretch window also drops o_rst[0].
  assign release_now_c = !req_c &&
                         (((state_q == ST_ASSERT) && (STRETCH_CYCLES == 1)) ||
                          ((state_q == ST_STRETCH) &&
                           (stretch_q == SCW'(STRETCH_CYCLES - 1))));

  always_comb begin
    cause_set_c                             = '0;
    cause_set_c[CAUSE_SRC_BASE +: NUM_SRC]  = src_req_c;
    cause_set_c[SW_BIT]                     = i_sw_rst;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_ASSERT;
      stretch_q <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      o_rst     <= '1;
      o_busy    <= 1'b1;
    end else if (req_c) begin
      state_q <= ST_ASSERT;
      o_rst   <= '1;
      o_busy  <= 1'b1;
    end else if (release_now_c) begin
      o_rst[0] <= 1'b0;
      idx_q    <= OCW'(1);
      gap_q    <= GCW'(1);
      if (NUM_OUT == 1) begin
        state_q <= ST_RUN;
        o_busy  <= 1'b0;
      end else begin
        state_q <= ST_RELEASE;
      end
    end else begin
      case (state_q)
        ST_ASSERT: begin
          state_q   <= ST_STRETCH;
          stretch_q <= SCW'(1);
        end
        ST_STRETCH: stretch_q <= stretch_q + SCW'(1);
        ST_RELEASE: begin
          if (gap_q == GCW'(GAP_CYCLES)) begin
            o_rst <= o_rst & ~(NUM_OUT'(1) << idx_q);
            if (idx_q == OCW'(NUM_OUT - 1)) begin
              state_q <= ST_RUN;
              o_busy  <= 1'b0;
            end else begin
              idx_q <= idx_q + OCW'(1);
              gap_q <= GCW'(1);
            end
          end else begin
            gap_q <= gap_q + GCW'(1);
          end
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_ASSERT;
      endcase
    end
  end

  // Sticky cause; a coincident set wins over the clear.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_cause            <= '0;
      o_cause[CAUSE_POR] <= 1'b1;
    end else begin
      o_cause <= (i_cause_clr ? '0 : o_cause) | cause_set_c;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; expectations are
// queued with the stimulus and popped when the outputs are sampled.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       i_rst;
  logic [1:0] i_src_rst;
  logic [1:0] i_src_en;
  logic       i_sw_rst;
  logic       i_cause_clr;
  logic [2:0] o_rst;
  logic       o_busy;
  logic [3:0] o_cause;

  typedef struct {
    string      tag;
    logic [2:0] rst;
    logic       busy;
    logic [3:0] cause;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  reset_sequencer dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_src_rst   (i_src_rst),
    .i_src_en    (i_src_en),
    .i_sw_rst    (i_sw_rst),
    .i_cause_clr (i_cause_clr),
    .o_rst       (o_rst),
    .o_busy      (o_busy),
    .o_cause     (o_cause)
  );

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic expect_out(input string tag, input logic [2:0] r,
                            input logic b, input logic [3:0] c);
    exp_t e;
    e.tag   = tag;
    e.rst   = r;
    e.busy  = b;
    e.cause = c;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [7:0] obs;
    logic [7:0] req;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed rst=%b busy=%b cause=%b", o_rst, o_busy, o_cause);
    end else begin
      e   = sb.pop_front();
      obs = {o_rst, o_busy, o_cause};
      req = {e.rst, e.busy, e.cause};
      assert (obs === req) else begin
        failures++;
        $error("FAIL %s observed rst=%b busy=%b cause=%b expected rst=%b busy=%b cause=%b",
               e.tag, o_rst, o_busy, o_cause, e.rst, e.busy, e.cause);
      end
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_after(input int n, input string tag, input logic [2:0] r,
                           input logic b, input logic [3:0] c);
    expect_out(tag, r, b, c);
    step(n);
    check_out();
  endtask

  initial begin
    i_rst       = 1'b1;
    i_src_rst   = 2'b00;
    i_src_en    = 2'b11;
    i_sw_rst    = 1'b0;
    i_cause_clr = 1'b0;

    // Power-on reset and the default release sequence
    #2;
    expect_out("por_hold", 3'b111, 1'b1, 4'b0001);
    check_out();
    step(3);
    i_rst = 1'b0;
    exp_after(7, "por_e7",  3'b111, 1'b1, 4'b0001);
    exp_after(1, "por_e8",  3'b110, 1'b1, 4'b0001);
    exp_after(4, "por_e12", 3'b110, 1'b1, 4'b0001);
    exp_after(1, "por_e13", 3'b100, 1'b1, 4'b0001);
    exp_after(4, "por_e17", 3'b100, 1'b1, 4'b0001);
    exp_after(1, "por_e18", 3'b000, 1'b0, 4'b0001);

    // Short pulse is filtered out
    i_src_rst[0] = 1'b1;
    step(2);
    i_src_rst[0] = 1'b0;
    exp_after(10, "glitch_2cyc", 3'b000, 1'b0, 4'b0001);

    // Four-cycle pulse qualifies; reset seven edges after the rise
    i_src_rst[0] = 1'b1;
    step(4);
    i_src_rst[0] = 1'b0;
    exp_after(2, "src0_e6", 3'b000, 1'b0, 4'b0001);
    exp_after(1, "src0_e7", 3'b111, 1'b1, 4'b0011);
    exp_after(7, "src0_e14", 3'b111, 1'b1, 4'b0011);
    exp_after(1, "src0_e15", 3'b110, 1'b1, 4'b0011);

    // Software retrigger one cycle into the release
    step(1);
    i_sw_rst = 1'b1;
    exp_after(1, "sw_assert", 3'b111, 1'b1, 4'b1011);
    i_sw_rst = 1'b0;
    exp_after(7, "sw_stretch", 3'b111, 1'b1, 4'b1011);
    exp_after(1, "sw_rel0", 3'b110, 1'b1, 4'b1011);
    exp_after(10, "sw_run", 3'b000, 1'b0, 4'b1011);

    // Lone cause clear
    i_cause_clr = 1'b1;
    exp_after(1, "cause_clr", 3'b000, 1'b0, 4'b0000);
    i_cause_clr = 1'b0;

    // Masked source, then enabled mid-pulse
    i_src_en     = 2'b01;
    i_src_rst[1] = 1'b1;
    exp_after(20, "mask_hold", 3'b000, 1'b0, 4'b0000);
    i_src_en = 2'b11;
    exp_after(1, "mask_enable", 3'b111, 1'b1, 4'b0100);
    i_src_rst[1] = 1'b0;
    exp_after(40, "mask_run", 3'b000, 1'b0, 4'b0100);

    // Source set coincident with a cause clear: set wins, old bit cleared
    i_src_rst[0] = 1'b1;
    step(4);
    i_src_rst[0] = 1'b0;
    step(2);
    i_cause_clr = 1'b1;
    exp_after(1, "clr_vs_set", 3'b111, 1'b1, 4'b0010);
    i_cause_clr = 1'b0;
    exp_after(30, "clr_run", 3'b000, 1'b0, 4'b0010);

    // Asynchronous reset with the clock stopped
    clk_run = 1'b0;
    #20;
    i_rst = 1'b1;
    #1;
    expect_out("async_rst", 3'b111, 1'b1, 4'b0001);
    check_out();
    #20;
    expect_out("async_hold", 3'b111, 1'b1, 4'b0001);
    check_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
